// File: rtl/audio_tone_pkg.sv
// Shared types and the waveform shaping function for the audio test-tone source.
// The shaper works on a fixed-width container; callers pass their real phase width.
package audio_tone_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'b00,
        WAVE_SQUARE = 2'b01,
        WAVE_TRI    = 2'b10,
        WAVE_SILENT = 2'b11
    } wave_mode_t;

    localparam int WAVE_MAX_WIDTH = 32;

    // Amplitude for one phase value; only the low `width` bits of the result are meaningful.
    function automatic logic [WAVE_MAX_WIDTH-1:0] wave_shape(
        input wave_mode_t                  mode,
        input logic [WAVE_MAX_WIDTH-1:0]   phase,
        input int                          width
    );
        logic [WAVE_MAX_WIDTH-1:0] ones;
        logic [WAVE_MAX_WIDTH-1:0] mask;
        logic [WAVE_MAX_WIDTH-1:0] msb_bit;
        logic [WAVE_MAX_WIDTH-1:0] tri_up;
        logic [WAVE_MAX_WIDTH-1:0] result;
        logic                      upper_half;

        ones       = '1;
        mask       = ones >> (WAVE_MAX_WIDTH - width);
        msb_bit    = mask & ~(mask >> 1);
        upper_half = ((phase & msb_bit) != '0);
        tri_up     = (phase << 1) & mask;

        case (mode)
            WAVE_SAW:    result = phase & mask;
            WAVE_SQUARE: result = upper_half ? mask : '0;
            WAVE_TRI:    result = upper_half ? (~tri_up & mask) : tri_up;
            default:     result = '0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/audio_tone_chan.sv
// One tone channel: phase accumulator advanced on each sample tick, latched mute,
// and the waveform mux producing the channel's sample word.
module audio_tone_chan
    import audio_tone_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int PHASE_WIDTH  = 8,
    parameter int PITCH_WIDTH  = 4,
    parameter int OUT_SHIFT    = 1
) (
    input  logic                    audio_clk_src,
    input  logic                    reset,
    input  logic                    tick_i,
    input  logic [PITCH_WIDTH-1:0]  pitch_i,
    input  logic                    mute_i,
    input  wave_mode_t              mode_i,
    output logic [SAMPLE_WIDTH-1:0] sample_o
);

    logic [PHASE_WIDTH-1:0]    phase_q;
    logic [PHASE_WIDTH-1:0]    phase_d;
    logic                      mute_q;
    logic                      mute_d;
    logic [WAVE_MAX_WIDTH-1:0] phase_ext;
    logic [WAVE_MAX_WIDTH-1:0] wave_full;
    logic                      wave_unused;

    // The increment is consumed on the tick edge itself, which is equivalent to
    // latching pitch there: changes between ticks never reach the accumulator.
    always_comb begin
        phase_d = phase_q;
        mute_d  = mute_q;
        if (tick_i) begin
            phase_d = phase_q + PHASE_WIDTH'(pitch_i);
            mute_d  = mute_i;
        end
    end

    always_ff @(posedge audio_clk_src or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            mute_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            mute_q  <= mute_d;
        end
    end

    always_comb begin
        phase_ext                  = '0;
        phase_ext[PHASE_WIDTH-1:0] = phase_q;
    end

    assign wave_full   = wave_shape(mode_i, phase_ext, PHASE_WIDTH);
    assign wave_unused = ^wave_full[WAVE_MAX_WIDTH-1:PHASE_WIDTH];

    always_comb begin
        sample_o = '0;
        if (!mute_q) begin
            sample_o[OUT_SHIFT +: PHASE_WIDTH] = wave_full[PHASE_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/audio_tone_gen.sv
// Multi-channel test-tone source on the audio PLL clock: internal sample-rate divider,
// per-channel tone generators and a valid/ready holding register with overrun flag.
module audio_tone_gen
    import audio_tone_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_WIDTH = 16,
    parameter int PHASE_WIDTH  = 8,
    parameter int PITCH_WIDTH  = 4,
    parameter int CLK_DIV      = 64,
    parameter int OUT_SHIFT    = 1
) (
    input  logic                                 audio_clk_src,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [1:0]                           mode,
    input  logic [NUM_CHANNELS*PITCH_WIDTH-1:0]  pitch,
    input  logic [NUM_CHANNELS-1:0]              mute,
    output logic                                 sample_clk,
    output logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_word,
    output logic                                 sample_valid,
    input  logic                                 sample_ready,
    output logic                                 overrun,
    input  logic                                 overrun_clr
);

    localparam int CNT_WIDTH = $clog2(CLK_DIV);
    localparam logic [CNT_WIDTH-1:0] DIV_LAST = CNT_WIDTH'(CLK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_HALF = CNT_WIDTH'(CLK_DIV / 2);

    generate
        if (PHASE_WIDTH + OUT_SHIFT > SAMPLE_WIDTH) begin : g_bad_shift
            $error("audio_tone_gen: PHASE_WIDTH+OUT_SHIFT exceeds SAMPLE_WIDTH");
        end
        if (PITCH_WIDTH > PHASE_WIDTH) begin : g_bad_pitch
            $error("audio_tone_gen: PITCH_WIDTH exceeds PHASE_WIDTH");
        end
        if ((CLK_DIV < 4) || (CLK_DIV % 2 != 0)) begin : g_bad_div
            $error("audio_tone_gen: CLK_DIV must be even and at least 4");
        end
        if (PHASE_WIDTH > WAVE_MAX_WIDTH) begin : g_bad_phase
            $error("audio_tone_gen: PHASE_WIDTH exceeds waveform container");
        end
    endgenerate

    logic [CNT_WIDTH-1:0]                 div_cnt_q;
    logic [CNT_WIDTH-1:0]                 div_cnt_d;
    logic                                 sample_clk_q;
    logic                                 sample_clk_d;
    logic                                 tick_pend_q;
    logic                                 tick_pend_d;
    wave_mode_t                           mode_q;
    wave_mode_t                           mode_d;
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] word_q;
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] word_d;
    logic                                 valid_q;
    logic                                 valid_d;
    logic                                 overrun_q;
    logic                                 overrun_d;
    logic                                 tick;
    logic                                 load;
    logic                                 overrun_set;
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] chan_word;

    always_comb begin
        div_cnt_d = div_cnt_q;
        tick      = 1'b0;
        if (enable) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                tick      = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + CNT_WIDTH'(1);
            end
        end
        // Registered from the next count so sample_clk tracks div_cnt exactly.
        sample_clk_d = (div_cnt_d >= DIV_HALF);
    end

    // A tick arms the load for the next enabled edge; the channels already hold
    // the advanced phase and latched mute/mode by then.
    always_comb begin
        load        = tick_pend_q && enable;
        tick_pend_d = tick || (tick_pend_q && !load);
        mode_d      = tick ? wave_mode_t'(mode) : mode_q;
    end

    always_comb begin
        word_d      = word_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        overrun_set = load && valid_q && !sample_ready;
        if (load) begin
            word_d  = chan_word;
            valid_d = 1'b1;
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge audio_clk_src or posedge reset) begin
        if (reset) begin
            div_cnt_q    <= '0;
            sample_clk_q <= 1'b0;
            tick_pend_q  <= 1'b0;
            mode_q       <= WAVE_SAW;
            word_q       <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            sample_clk_q <= sample_clk_d;
            tick_pend_q  <= tick_pend_d;
            mode_q       <= mode_d;
            word_q       <= word_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            audio_tone_chan #(
                .SAMPLE_WIDTH (SAMPLE_WIDTH),
                .PHASE_WIDTH  (PHASE_WIDTH),
                .PITCH_WIDTH  (PITCH_WIDTH),
                .OUT_SHIFT    (OUT_SHIFT)
            ) u_chan (
                .audio_clk_src (audio_clk_src),
                .reset         (reset),
                .tick_i        (tick),
                .pitch_i       (pitch[gi*PITCH_WIDTH +: PITCH_WIDTH]),
                .mute_i        (mute[gi]),
                .mode_i        (mode_q),
                .sample_o      (chan_word[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH])
            );
        end
    endgenerate

    assign sample_clk   = sample_clk_q;
    assign sample_word  = word_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_audio_tone_gen.sv
// Randomised bench for audio_tone_gen: a sample-level reference model predicts
// every output each cycle from counted enabled edges and plain phase arithmetic.
module tb_audio_tone_gen;

    localparam int NCH = 2;
    localparam int SW  = 16;
    localparam int PW  = 8;
    localparam int PIW = 4;
    localparam int DIV = 64;
    localparam int SH  = 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [1:0]          mode;
    logic [NCH*PIW-1:0]  pitch;
    logic [NCH-1:0]      mute;
    logic                sample_clk;
    logic [NCH*SW-1:0]   sample_word;
    logic                sample_valid;
    logic                sample_ready;
    logic                overrun;
    logic                overrun_clr;

    always #5 clk = ~clk;

    audio_tone_gen #(
        .NUM_CHANNELS (NCH),
        .SAMPLE_WIDTH (SW),
        .PHASE_WIDTH  (PW),
        .PITCH_WIDTH  (PIW),
        .CLK_DIV      (DIV),
        .OUT_SHIFT    (SH)
    ) dut (
        .audio_clk_src (clk),
        .reset         (reset),
        .enable        (enable),
        .mode          (mode),
        .pitch         (pitch),
        .mute          (mute),
        .sample_clk    (sample_clk),
        .sample_word   (sample_word),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          n_en;
    bit          pend;
    int          phase_m [NCH];
    int          mode_l;
    bit [NCH-1:0] mute_l;
    logic [NCH*SW-1:0] exp_word;
    bit          exp_valid;
    bit          exp_ovr;
    int          loads = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wave_of(input int m, input int p);
        int half;
        int full;
        half = 1 << (PW - 1);
        full = (1 << PW) - 1;
        case (m)
            0: return p;
            1: return (p >= half) ? full : 0;
            2: return (p < half) ? 2 * p : full - 2 * (p - half);
            default: return 0;
        endcase
    endfunction

    function automatic logic [NCH*SW-1:0] expected_word();
        logic [NCH*SW-1:0] w;
        int v;
        w = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            v = mute_l[ch] ? 0 : (wave_of(mode_l, phase_m[ch]) << SH);
            w[ch*SW +: SW] = v[SW-1:0];
        end
        return w;
    endfunction

    task automatic model_reset();
        n_en      = 0;
        pend      = 1'b0;
        for (int ch = 0; ch < NCH; ch++) phase_m[ch] = 0;
        mode_l    = 0;
        mute_l    = '0;
        exp_word  = '0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    // Applies one rising edge to the model using the inputs present at that edge.
    task automatic model_edge();
        bit load;
        bit tick;
        bit set;
        if (reset) begin
            model_reset();
            return;
        end
        load = pend && enable;
        tick = 1'b0;
        if (enable) begin
            n_en++;
            tick = (n_en % DIV == 0);
        end
        set = 1'b0;
        if (load) begin
            set       = exp_valid && !sample_ready;
            exp_valid = 1'b1;
            exp_word  = expected_word();
            loads++;
            $display("load %0d: t=%0t mode=%0d word=%08h overwrite=%0d", loads, $time, mode_l, exp_word, set);
        end else if (exp_valid && sample_ready) begin
            exp_valid = 1'b0;
        end
        if (set) exp_ovr = 1'b1;
        else if (overrun_clr) exp_ovr = 1'b0;
        if (load) pend = 1'b0;
        if (tick) begin
            pend = 1'b1;
            for (int ch = 0; ch < NCH; ch++)
                phase_m[ch] = (phase_m[ch] + int'(pitch[ch*PIW +: PIW])) % (1 << PW);
            mode_l = int'(mode);
            mute_l = mute;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("valid", sample_valid, exp_valid);
        check_eq("overrun", overrun, exp_ovr);
        check_eq("sample_clk", sample_clk, ((n_en % DIV) >= DIV / 2));
        check_eq("word", sample_word, exp_word);
    endtask

    initial begin
        int len;
        int ready_mode;
        int en_mode;
        int off_cnt;
        reset        = 1'b1;
        enable       = 1'b0;
        mode         = 2'b00;
        pitch        = '0;
        mute         = '0;
        sample_ready = 1'b1;
        overrun_clr  = 1'b0;
        model_reset();
        repeat (2) step();
        check_eq("rst_word", sample_word, 0);
        check_eq("rst_valid", sample_valid, 0);
        check_eq("rst_clk", sample_clk, 0);
        check_eq("rst_overrun", overrun, 0);

        // Default saw, pitch 1 on both channels
        reset  = 1'b0;
        enable = 1'b1;
        pitch  = 8'h11;
        repeat (64) step();
        check_eq("first_valid_early", sample_valid, 0);
        step();
        check_eq("first_valid", sample_valid, 1);
        check_eq("first_word", sample_word, 32'h0002_0002);
        repeat (64) step();
        check_eq("second_word", sample_word, 32'h0004_0004);

        // Randomised segments with mid-period input changes, stalls, pauses and resets
        off_cnt = 0;
        for (int seg = 0; seg < 60; seg++) begin
            mode       = 2'($urandom_range(0, 3));
            pitch      = NCH*PIW'($urandom);
            mute       = NCH'($urandom_range(0, 3) == 0 ? $urandom : 0);
            ready_mode = $urandom_range(0, 2);
            en_mode    = $urandom_range(0, 1);
            len        = $urandom_range(20, 200);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 99) == 0) mode = 2'($urandom);
                if ($urandom_range(0, 99) == 0) pitch = NCH*PIW'($urandom);
                case (ready_mode)
                    0:       sample_ready = 1'b1;
                    1:       sample_ready = 1'($urandom);
                    default: sample_ready = 1'b0;
                endcase
                overrun_clr = ($urandom_range(0, 15) == 0);
                if (off_cnt > 0) begin
                    enable  = 1'b0;
                    off_cnt--;
                end else if (en_mode == 1 && !pend && $urandom_range(0, 49) == 0) begin
                    enable  = 1'b0;
                    off_cnt = $urandom_range(1, 100);
                end else begin
                    enable  = 1'b1;
                end
                if ((seg == 30 && c == len / 2) || $urandom_range(0, 799) == 0) begin
                    reset = 1'b1;
                    #1;
                    check_eq("async_rst_word", sample_word, 0);
                    check_eq("async_rst_valid", sample_valid, 0);
                    check_eq("async_rst_clk", sample_clk, 0);
                    check_eq("async_rst_overrun", overrun, 0);
                    model_reset();
                    step();
                    reset = 1'b0;
                end
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
